// File: rtl/clk_div_monitor.sv
// Checks a divided clock, sampled as data in the clkin domain: it measures period and high time, and reports lock, mismatch and loss-of-clock.
// Define CLK_MON_SYNC_EN to put div_clk through a 2-flop synchronizer; without it div_clk is sampled once.
module clk_div_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] divisor,
  input  logic        div_clk,
  output logic [15:0] period,
  output logic [15:0] high_cnt,
  output logic        meas_valid,
  output logic        locked,
  output logic        mismatch,
  output logic        timeout
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [4:0]  LOCK_W    = 5'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCK} state_t;

  state_t      state_reg, state_next;
  logic        s_reg, d_reg;
  logic [15:0] cnt_reg, cnt_next, hcnt_reg, hcnt_next;
  logic [3:0]  match_reg, match_next;
  logic [15:0] period_next, high_next;
  logic        mv_next, mm_next, locked_next, timeout_next;

`ifdef CLK_MON_SYNC_EN
  logic meta_reg;
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      meta_reg <= 1'b0;
      s_reg    <= 1'b0;
    end else begin
      meta_reg <= div_clk;
      s_reg    <= meta_reg;
    end
  end
`else
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) s_reg <= 1'b0;
    else        s_reg <= div_clk;
  end
`endif

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) d_reg <= 1'b0;
    else        d_reg <= s_reg;
  end

  logic        rise;
  logic [15:0] cnt_inc, hcnt_inc;
  logic [16:0] half_up;
  logic        check_en, period_ok, high_ok, timeout_hit;

  assign rise        = s_reg & ~d_reg;
  assign cnt_inc     = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
  assign hcnt_inc    = (hcnt_reg == 16'hFFFF) ? hcnt_reg : hcnt_reg + 16'd1;
  // Odd divisors may legitimately place the extra cycle in either half.
  assign half_up     = ({1'b0, divisor} + 17'd1) >> 1;
  assign check_en    = divisor >= 16'd2;
  assign period_ok   = cnt_reg == divisor;
  assign high_ok     = (hcnt_reg == (divisor >> 1)) || ({1'b0, hcnt_reg} == half_up);
  assign timeout_hit = cnt_reg >= TIMEOUT_W;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hcnt_next    = hcnt_reg;
    match_next   = match_reg;
    period_next  = period;
    high_next    = high_cnt;
    mv_next      = 1'b0;
    mm_next      = 1'b0;
    locked_next  = locked;
    timeout_next = timeout;
    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        hcnt_next    = '0;
        match_next   = '0;
        locked_next  = 1'b0;
        timeout_next = 1'b0;
        if (en) state_next = ARM;
      end
      ARM: begin
        if (!en) begin
          state_next = IDLE;
        end else if (rise) begin
          cnt_next     = 16'd1;
          hcnt_next    = 16'd1;
          timeout_next = 1'b0;
          state_next   = MEAS;
        end else if (timeout_hit) begin
          timeout_next = 1'b1;
          locked_next  = 1'b0;
          match_next   = '0;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        if (!en) begin
          state_next = IDLE;
        end else if (rise) begin
          period_next  = cnt_reg;
          high_next    = hcnt_reg;
          mv_next      = 1'b1;
          cnt_next     = 16'd1;
          hcnt_next    = 16'd1;
          timeout_next = 1'b0;
          if (!check_en) begin
            match_next  = '0;
            locked_next = 1'b0;
            state_next  = MEAS;
          end else if (period_ok && high_ok) begin
            if ({1'b0, match_reg} + 5'd1 >= LOCK_W) begin
              match_next  = LOCK_W[3:0];
              locked_next = 1'b1;
              state_next  = LOCK;
            end else begin
              match_next = match_reg + 4'd1;
              state_next = MEAS;
            end
          end else begin
            mm_next     = 1'b1;
            match_next  = '0;
            locked_next = 1'b0;
            state_next  = MEAS;
          end
        end else if (timeout_hit) begin
          timeout_next = 1'b1;
          locked_next  = 1'b0;
          match_next   = '0;
          cnt_next     = '0;
          hcnt_next    = '0;
          state_next   = ARM;
        end else begin
          cnt_next = cnt_inc;
          if (s_reg) hcnt_next = hcnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      match_reg  <= '0;
      period     <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hcnt_reg   <= hcnt_next;
      match_reg  <= match_next;
      period     <= period_next;
      high_cnt   <= high_next;
      meas_valid <= mv_next;
      mismatch   <= mm_next;
      locked     <= locked_next;
      timeout    <= timeout_next;
    end
  end

endmodule
